// File: rtl/val_pkg.sv
// Shared constants and helpers for the VAL input conditioner.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package val_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Smallest r with 2**r >= value; used to size the per-bit debounce counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/val_debouncer_if.sv
// Groups the raw switch inputs and the conditioned VAL/RISE/FALL/CHANGED outputs.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are free-running levels and pulses.
// Ports: raw_in (to conditioner), val/rise/fall (per bit), changed (any event).
interface val_debouncer_if #(
  parameter int WIDTH = val_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  // master: the switch side / consumer; slave: the conditioner itself.
  modport master (output raw_in, input val, rise, fall, changed);
  modport slave  (input raw_in, output val, rise, fall, changed);

endinterface

// File: rtl/debounce_bit.sv
// One-bit conditioner: two-flop synchroniser, counter debounce, rise/fall pulses.
// Latency: VAL follows a stable RAW change DEBOUNCE_CYCLES+2 edges after it is sampled.
// Backpressure: none; pulses last exactly one cycle.
// Ports: clk, rst (sync, active high), raw in; val, rise, fall registered outs;
//        evt_nxt is the combinational "pulse fires at the next edge" term for the top.
module debounce_bit
  import val_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4  // must be >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic val,
  output logic rise,
  output logic fall,
  output logic evt_nxt
);

  localparam int                   CNT_WIDTH = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 differ;
  logic                 settle;
  logic                 rise_nxt;
  logic                 fall_nxt;

  // The bit is "pending" while the synchronised level disagrees with VAL;
  // it settles on the edge where the counter has already seen
  // DEBOUNCE_CYCLES-1 disagreeing edges.
  always_comb begin
    differ   = (sync2 != val);
    settle   = differ && (cnt == CNT_LAST);
    rise_nxt = settle &  sync2;
    fall_nxt = settle & ~sync2;
    evt_nxt  = settle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      val   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      if (!differ) begin
        // Agreement (including a bounce back) discards any partial count.
        cnt <= '0;
      end else if (settle) begin
        val <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/val_debouncer.sv
// WIDTH-bit input conditioner feeding the SUB stage VAL bus.
// Latency: DEBOUNCE_CYCLES+2 edges from a stable raw change to VAL/RISE/FALL/CHANGED.
// Backpressure: none; events are single-cycle pulses.
// Ports: clk, rst (sync, active high); bus.slave carries raw_in in and
//        val/rise/fall (per bit) plus changed (OR of all pulses) out.
module val_debouncer
  import val_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  val_debouncer_if.slave    bus
);

  logic [WIDTH-1:0] raw_w;
  logic [WIDTH-1:0] val_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] evt_w;
  logic             changed_q;

  assign raw_w       = bus.raw_in;
  assign bus.val     = val_w;
  assign bus.rise    = rise_w;
  assign bus.fall    = fall_w;
  assign bus.changed = changed_q;

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) inst_db[WIDTH-1:0] (
    .clk     (clk),
    .rst     (rst),
    .raw     (raw_w),
    .val     (val_w),
    .rise    (rise_w),
    .fall    (fall_w),
    .evt_nxt (evt_w)
  );

  // Registered from the per-bit next-state pulses so CHANGED lands in the
  // same cycle as RISE/FALL rather than one cycle behind them.
  always_ff @(posedge clk) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= |evt_w;
  end

endmodule

// File: tb/tb_val_debouncer.sv
// Self-checking bench for val_debouncer: directed scenarios plus a random run
// compared against a history-based reference model.
module tb_val_debouncer;

  localparam int W = 4;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  val_debouncer_if #(.WIDTH(W)) bus ();

  val_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[j] holds RAW_IN as sampled at edge j+1 after reset. The level the
  // design sees at edge k is RAW_IN from edge k-2 (zero before that). A bit
  // flips when at least D edges have passed since its last flip and the D most
  // recent seen levels all disagree with the current VAL.
  logic [W-1:0] hist[$];
  int           k;
  int           since[W];
  logic [W-1:0] m_val, m_rise, m_fall;
  logic         m_chg;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      k      = 0;
      m_val  = '0;
      m_rise = '0;
      m_fall = '0;
      m_chg  = 1'b0;
      for (int b = 0; b < W; b++) since[b] = 0;
    end else begin
      k++;
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        bit all_diff;
        since[b]++;
        if (since[b] >= D) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) begin
            int   idx;
            logic lvl;
            idx = k - j - 3;
            lvl = (idx >= 0) ? hist[idx][b] : 1'b0;
            if (lvl == m_val[b]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_val[b]  = ~m_val[b];
            m_rise[b] = m_val[b];
            m_fall[b] = ~m_val[b];
            since[b]  = 0;
          end
        end
      end
      hist.push_back(bus.raw_in);
      m_chg = |(m_rise | m_fall);
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.raw_in = 4'b0000;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      vectors++;
      if ({bus.val, bus.rise, bus.fall, bus.changed} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset e%0d: val=%b rise=%b fall=%b chg=%b want all 0",
                 e, bus.val, bus.rise, bus.fall, bus.changed);
      end
    end
  endtask

  task automatic test_clean_step();
    logic [W-1:0] ev, er;
    rst = 1'b0;
    bus.raw_in = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      ev = (e >= 6) ? 4'b0001 : 4'b0000;
      er = (e == 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if (bus.val !== ev || bus.rise !== er || bus.fall !== 4'b0 || bus.changed !== (e == 6)) begin
        miscompares++;
        $display("FAIL clean_step e%0d: val=%b rise=%b fall=%b chg=%b want val=%b rise=%b fall=0000 chg=%0d",
                 e, bus.val, bus.rise, bus.fall, bus.changed, ev, er, (e == 6));
      end
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] ev, er;
    for (int p = 0; p < 4; p++) begin
      bus.raw_in = (p % 2 == 0) ? 4'b0101 : 4'b0001;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vectors++;
        if (bus.rise !== 4'b0 || bus.fall !== 4'b0 || bus.changed !== 1'b0 || bus.val !== 4'b0001) begin
          miscompares++;
          $display("FAIL bounce p%0d c%0d: val=%b rise=%b fall=%b chg=%b want val=0001, no pulses",
                   p, c, bus.val, bus.rise, bus.fall, bus.changed);
        end
      end
    end
    bus.raw_in = 4'b0101;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      ev = (e >= 6) ? 4'b0101 : 4'b0001;
      er = (e == 6) ? 4'b0100 : 4'b0000;
      vectors++;
      if (bus.val !== ev || bus.rise !== er || bus.fall !== 4'b0 || bus.changed !== (e == 6)) begin
        miscompares++;
        $display("FAIL bounce_settle e%0d: val=%b rise=%b chg=%b want val=%b rise=%b chg=%0d",
                 e, bus.val, bus.rise, bus.changed, ev, er, (e == 6));
      end
    end
  endtask

  task automatic test_falling();
    logic [W-1:0] ev, ef;
    bus.raw_in = 4'b1111;
    repeat (8) @(negedge clk);
    vectors++;
    if (bus.val !== 4'b1111) begin
      miscompares++;
      $display("FAIL falling_setup: val=%b want 1111", bus.val);
    end
    bus.raw_in = 4'b0101;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      ev = (e >= 6) ? 4'b0101 : 4'b1111;
      ef = (e == 6) ? 4'b1010 : 4'b0000;
      vectors++;
      if (bus.val !== ev || bus.fall !== ef || bus.rise !== 4'b0 || bus.changed !== (e == 6)) begin
        miscompares++;
        $display("FAIL falling e%0d: val=%b rise=%b fall=%b chg=%b want val=%b rise=0000 fall=%b chg=%0d",
                 e, bus.val, bus.rise, bus.fall, bus.changed, ev, ef, (e == 6));
      end
    end
  endtask

  task automatic test_glitch();
    bus.raw_in = 4'b1101;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) bus.raw_in = 4'b0101;
      @(negedge clk);
      vectors++;
      if (bus.val !== 4'b0101 || bus.rise !== 4'b0 || bus.fall !== 4'b0 || bus.changed !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch c%0d: val=%b rise=%b fall=%b chg=%b want val=0101, no pulses",
                 c, bus.val, bus.rise, bus.fall, bus.changed);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [W-1:0] er;
    rst = 1'b1;
    bus.raw_in = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.raw_in = 4'b1000;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      vectors++;
      if (bus.val !== 4'b0 || bus.rise !== 4'b0 || bus.changed !== 1'b0) begin
        miscompares++;
        $display("FAIL midcount_pre e%0d: val=%b rise=%b chg=%b want 0", e, bus.val, bus.rise, bus.changed);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.val !== 4'b0 || bus.rise !== 4'b0 || bus.changed !== 1'b0) begin
      miscompares++;
      $display("FAIL midcount_rst: val=%b rise=%b chg=%b want 0", bus.val, bus.rise, bus.changed);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      er = (e == 6) ? 4'b1000 : 4'b0000;
      vectors++;
      if (bus.rise !== er || bus.changed !== (e == 6) || bus.val[3] !== (e >= 6)) begin
        miscompares++;
        $display("FAIL midcount_post e%0d: val=%b rise=%b chg=%b want rise=%b chg=%0d val3=%0d",
                 e, bus.val, bus.rise, bus.changed, er, (e == 6), (e >= 6));
      end
    end
  endtask

  task automatic test_independence();
    logic [W-1:0] er;
    bus.raw_in = 4'b1001;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      er = (e == 6) ? 4'b0001 : (e == 8) ? 4'b0010 : 4'b0000;
      vectors++;
      if (bus.rise !== er || bus.fall !== 4'b0 || bus.changed !== (e == 6 || e == 8)) begin
        miscompares++;
        $display("FAIL independence e%0d: rise=%b fall=%b chg=%b want rise=%b chg=%0d",
                 e, bus.rise, bus.fall, bus.changed, er, (e == 6 || e == 8));
      end
      if (e == 2) bus.raw_in = 4'b1011;
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    bus.raw_in = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.raw_in = bus.raw_in ^ 4'($urandom_range(1, 15));
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      vectors++;
      if (bus.val !== m_val || bus.rise !== m_rise || bus.fall !== m_fall || bus.changed !== m_chg) begin
        miscompares++;
        $display("FAIL random c%0d: val=%b rise=%b fall=%b chg=%b want val=%b rise=%b fall=%b chg=%b",
                 c, bus.val, bus.rise, bus.fall, bus.changed, m_val, m_rise, m_fall, m_chg);
      end
      vectors++;
      if ((bus.rise & bus.fall) !== 4'b0) begin
        miscompares++;
        $display("FAIL random_mutex c%0d: rise=%b fall=%b overlap", c, bus.rise, bus.fall);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.raw_in  = '0;
    @(negedge clk);
    test_reset();
    test_clean_step();
    test_bounce();
    test_falling();
    test_glitch();
    test_reset_midcount();
    test_independence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/val_debouncer.md
Name: val_debouncer

Overview:
Input conditioner directly upstream of the SUB/LED stage. It takes asynchronous raw switch/button levels and produces the clean, clock-synchronous VAL bus consumed by the SUB instance arrays. Per bit, it performs two-flop synchronisation, then counter-based debounce, then one-cycle rise/fall event pulses. The per-bit logic is instantiated as an instance array, matching the downstream stage's structure.

Parameters:
WIDTH, 4, number of independent input bits (matches the VAL bus width).
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before VAL follows the input; legal range >=1.
CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, never overridden.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
RAW_IN  input  WIDTH  asynchronous raw switch levels; may bounce.
VAL  output  WIDTH  debounced level per bit; feeds the SUB stage VAL inputs.
RISE  output  WIDTH  one-cycle pulse per bit when VAL[i] goes 0->1.
FALL  output  WIDTH  one-cycle pulse per bit when VAL[i] goes 1->0.
CHANGED  output  1  OR of RISE|FALL; registered, same cycle as the pulses.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RST). While RST=1 at an edge, all of the following clear to 0: sync1, sync2, cnt, VAL, RISE, FALL, CHANGED. No async paths.
- Synchroniser: per bit, sync1<=RAW_IN[i], then sync2<=sync1. No logic between the two flops.
- Per-bit FSM, implicit in cnt:
  - STABLE: cnt==0 and sync2==VAL[i].
  - PENDING: sync2!=VAL[i].
- Each edge, with RST=0:
  - If sync2==VAL[i]: cnt<=0; no pulse. This aborts any pending change (bounce rejection).
  - Else if cnt==DEBOUNCE_CYCLES-1: VAL[i]<=sync2; cnt<=0; RISE[i]<=sync2; FALL[i]<=~sync2.
  - Else: cnt<=cnt+1.
- Pulses: RISE/FALL are asserted only in the cycle VAL[i] changes and clear on the next edge. They never assert together for one bit. CHANGED follows the same rule.
- Latency: RAW_IN changes before edge 1 and stays stable. sync2 differs from edge 2. VAL updates at edge 2+DEBOUNCE_CYCLES (edge 6 with the default). With DEBOUNCE_CYCLES=1, VAL updates at edge 3.
- Bounce: any return of sync2 to VAL[i] before the count completes restarts the count from 0. The net pulse count therefore never exceeds real settled transitions.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Bits are fully independent. Simultaneous changes on several bits yield simultaneous pulses. CHANGED stays a single one-cycle pulse.
- Reset mid-count: the pending change is discarded. After release, VAL restarts at 0 and re-qualifies RAW_IN from scratch. A bit held at 1 across reset produces RISE at edge 2+DEBOUNCE_CYCLES after release.
- RAW_IN constant at 0 from reset: no pulses ever.

Decomposition:
- Shared package val_pkg:
  - localparam DEFAULT_WIDTH=4.
  - function clog2 helper for CNT_WIDTH.
  - Typedef-free. Values are exposed as parameters only, for Verilog-2001 compatibility.
- Sub-module debounce_bit:
  - Ports: CLK, RST, RAW (1), VAL (1), RISE (1), FALL (1); parameter DEBOUNCE_CYCLES.
  - Instantiated in val_debouncer as instance array inst_db[WIDTH-1:0] (RAW_IN, VAL, RISE, FALL).
- CHANGED is registered in the top as the OR of the next-state pulses, so it aligns with RISE/FALL.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=4.
1. Reset then clean step: RST high 3 edges with RAW_IN=4'b0000, then RAW_IN=4'b0001 before edge 1 after release -> VAL=4'b0001 at edge 6; RISE=4'b0001 and CHANGED=1 for exactly that cycle; all outputs 0 during reset.
2. Bounce rejection: RAW_IN[2] toggles 1,0,1,0 for 3 cycles each, then holds 1 -> no pulses during bouncing; single RISE[2] exactly 2+4 edges after the final settle; VAL[2]=1.
3. Falling edge: VAL=4'b1111 stable, RAW_IN=4'b0101 -> at edge 6: VAL=4'b0101, FALL=4'b1010, RISE=0, CHANGED=1 for one cycle.
4. Short glitch: RAW_IN[3] high for 3 cycles then low -> VAL[3] stays 0; RISE/FALL/CHANGED never assert.
5. Reset mid-count: RAW_IN=4'b1000 held; assert RST at edge 4 for 1 cycle -> no pulse before reset; VAL clears; RISE[3] at edge 6 after RST release.
6. Per-bit independence: bit0 rises at t, bit1 rises at t+2 -> RISE=4'b0001 at edge t+6, RISE=4'b0010 at edge t+8; CHANGED pulses twice, each one cycle.
